rom_init_loader: RTL and testbench

ROM_INIT_LOADER -- requirements
Module: rom_init_loader

---
 rtl/rom_init_loader.sv | 159 +++++++++++++++
 tb/tb_rom_init_loader.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/rom_init_loader.sv
// rtl/rom_init_loader.sv - byte-stream ROM initialization loader; optional readback verify via ROM_INIT_LOADER_VERIFY_EN
module rom_init_loader (
  input  logic        clk_i,
  input  logic        res_i,
  input  logic        start_i,
  input  logic [11:0] len_i,
  input  logic        s_valid_i,
  input  logic [7:0]  s_data_i,
  output logic        s_ready_o,
  output logic        rom_init_enb_o,
  output logic [11:0] rom_init_addr_o,
  output logic        rom_init_re_o,
  output logic        rom_init_we_o,
  output logic [7:0]  rom_init_wdata_o,
  input  logic [7:0]  rom_init_rdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  typedef enum logic [2:0] {IDLE, WRITE, FLUSH, VERIFY, VWAIT, FINISH} state_e;

  state_e      state_q, state_d;
  logic [12:0] cnt_q;
  logic [11:0] idx_q;
  logic [11:0] addr_q;
  logic [7:0]  wdata_q;
  logic [7:0]  chk_q;
  logic        we_q;
  logic        done_q;
  logic        xfer;

  assign xfer             = s_ready_o & s_valid_i;
  assign s_ready_o        = (state_q == WRITE) && (cnt_q != 13'd0);
  assign rom_init_enb_o   = (state_q != IDLE);
  assign busy_o           = (state_q != IDLE);
  assign rom_init_addr_o  = addr_q;
  assign rom_init_we_o    = we_q;
  assign rom_init_wdata_o = wdata_q;
  assign done_o           = done_q;

`ifdef ROM_INIT_LOADER_VERIFY_EN
  logic [12:0] len_q;
  logic [7:0]  vsum_q;
  logic [7:0]  vsum_next;
  logic        rd_pend_q;
  logic        err_q;

  assign vsum_next     = vsum_q + rom_init_rdata_i;
  assign rom_init_re_o = (state_q == VERIFY);
  assign err_o         = err_q;

  // Readback accumulator: the datum for each read strobe arrives one cycle later
  always_ff @(posedge clk_i) begin
    if (res_i) begin
      len_q     <= 13'd0;
      vsum_q    <= 8'h00;
      rd_pend_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      rd_pend_q <= (state_q == VERIFY);
      if (state_q == IDLE && start_i) begin
        len_q <= {(len_i == 12'd0), len_i};
        err_q <= 1'b0;
      end
      if (state_q == FLUSH) begin
        vsum_q <= 8'h00;
      end else if (rd_pend_q) begin
        vsum_q <= vsum_next;
      end
      if (state_q == VWAIT) begin
        err_q <= (vsum_next != chk_q);
      end
    end
  end
`else
  logic unused_rdata;

  assign unused_rdata  = ^rom_init_rdata_i;
  assign rom_init_re_o = 1'b0;
  assign err_o         = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (res_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (start_i) state_d = WRITE;
      WRITE:  if (xfer && cnt_q == 13'd1) state_d = FLUSH;
`ifdef ROM_INIT_LOADER_VERIFY_EN
      FLUSH:  state_d = VERIFY;
      VERIFY: if (cnt_q == 13'd1) state_d = VWAIT;
      VWAIT:  state_d = FINISH;
`else
      FLUSH:  state_d = FINISH;
`endif
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write datapath: one strobe per accepted byte; DONE is registered off FINISH
  always_ff @(posedge clk_i) begin
    if (res_i) begin
      cnt_q   <= 13'd0;
      idx_q   <= 12'h000;
      addr_q  <= 12'h000;
      wdata_q <= 8'h00;
      chk_q   <= 8'h00;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      we_q   <= 1'b0;
      done_q <= (state_q == FINISH);
      case (state_q)
        IDLE: begin
          if (start_i) begin
            cnt_q  <= {(len_i == 12'd0), len_i};
            idx_q  <= 12'h000;
            addr_q <= 12'h000;
            chk_q  <= 8'h00;
          end
        end
        WRITE: begin
          if (xfer) begin
            we_q    <= 1'b1;
            addr_q  <= idx_q;
            wdata_q <= s_data_i;
            idx_q   <= idx_q + 12'd1;
            chk_q   <= chk_q + s_data_i;
            cnt_q   <= cnt_q - 13'd1;
          end
        end
`ifdef ROM_INIT_LOADER_VERIFY_EN
        FLUSH: begin
          addr_q <= 12'h000;
          cnt_q  <= len_q;
        end
        VERIFY: begin
          // Hold the last address rather than wrapping past 0xFFF
          if (cnt_q != 13'd1) addr_q <= addr_q + 12'd1;
          cnt_q <= cnt_q - 13'd1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_init_loader.sv
// tb/tb_rom_init_loader.sv - self-checking bench for rom_init_loader with stream driver, ROM model and load scoreboard
module tb_rom_init_loader;

  logic        clk;
  logic        res;
  logic        start;
  logic [11:0] len;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        enb;
  logic [11:0] addr;
  logic        re;
  logic        we;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        busy;
  logic        done;
  logic        err;

  rom_init_loader dut (
    .clk_i(clk), .res_i(res), .start_i(start), .len_i(len),
    .s_valid_i(s_valid), .s_data_i(s_data), .s_ready_o(s_ready),
    .rom_init_enb_o(enb), .rom_init_addr_o(addr), .rom_init_re_o(re),
    .rom_init_we_o(we), .rom_init_wdata_o(wdata), .rom_init_rdata_i(rdata),
    .busy_o(busy), .done_o(done), .err_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int overlap = 0;
  int busy_low, addr_bad, err_after_start;
  bit corrupt = 1'b0;

  logic [7:0] tx[$];
  logic [7:0] mem [0:4095];
  int wa[$], wd[$], wc[$], dc[$], de[$], ra[$];

  always @(posedge clk) cyc <= cyc + 1;

  // ROM model: registered read, optional corruption at address 1
  always @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= (corrupt && addr == 12'h001) ? 8'h00 : mem[addr];
  end

  // Strobe monitor
  always @(negedge clk) begin
    if (we) begin wa.push_back(int'(addr)); wd.push_back(int'(wdata)); wc.push_back(cyc); end
    if (re) ra.push_back(int'(addr));
    if (done) begin dc.push_back(cyc); de.push_back(int'(err)); end
    if (re && we) overlap++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    wa.delete(); wd.delete(); wc.delete(); dc.delete(); de.delete(); ra.delete();
  endtask

  task automatic fill_tx(input int n);
    tx.delete();
    for (int i = 0; i < n; i++) tx.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic run_load(input int n, input int fixed_gap, input int rand_gap, input bit poke);
    int sent, gap, guard;
    bit xfer;
    sent = 0; gap = 0; guard = 0; busy_low = 0; addr_bad = 0;
    @(negedge clk);
    clear_logs();
    start = 1'b1; len = n[11:0];
    @(negedge clk);
    start = 1'b0;
    err_after_start = int'(err);
    while (sent < n && guard < 20000) begin
      if (!busy) busy_low++;
      if (addr !== ((sent > 0) ? 12'(sent - 1) : 12'h000)) addr_bad++;
      if (poke && sent == 1) begin start = 1'b1; len = 12'd7; end else start = 1'b0;
      if (gap > 0) begin s_valid = 1'b0; gap--; end
      else begin s_valid = 1'b1; s_data = tx[sent]; end
      xfer = s_valid && s_ready;
      @(negedge clk);
      guard++;
      if (xfer) begin
        sent++;
        gap = fixed_gap + ((rand_gap > 0) ? int'($urandom_range(0, rand_gap)) : 0);
      end
    end
    start = 1'b0; s_valid = 1'b0;
    check("load_guard", guard < 20000, 1);
    guard = 0;
    while (dc.size() == 0 && guard < 5000) begin @(negedge clk); guard++; end
    check("done_guard", guard < 5000, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_load(input string tag, input int n, input bit exp_err);
    int bad, exp_lat, exp_re;
`ifdef ROM_INIT_LOADER_VERIFY_EN
    exp_lat = n + 3; exp_re = n;
`else
    exp_lat = 2; exp_re = 0;
`endif
    bad = 0;
    for (int i = 0; i < wa.size() && i < n; i++) if (wa[i] != i || wd[i] != int'(tx[i])) bad++;
    check({tag, "_we_count"}, wa.size(), n);
    check({tag, "_we_seq"}, bad, 0);
    check({tag, "_done_count"}, dc.size(), 1);
    if (dc.size() > 0 && wc.size() > 0) check({tag, "_done_lat"}, dc[0] - wc[wc.size() - 1], exp_lat);
    if (de.size() > 0) check({tag, "_err_at_done"}, de[0], int'(exp_err));
    check({tag, "_busy_low"}, busy_low, 0);
    check({tag, "_addr_hold"}, addr_bad, 0);
    check({tag, "_err_clr"}, err_after_start, 0);
    bad = 0;
    for (int i = 0; i < ra.size(); i++) if (ra[i] != i) bad++;
    check({tag, "_re_count"}, ra.size(), exp_re);
    check({tag, "_re_seq"}, bad, 0);
  endtask

  initial begin
    int sent, guard, n;
    bit xfer;
    res = 1'b1; start = 1'b0; len = 12'h000; s_valid = 1'b0; s_data = 8'h00; rdata = 8'h00;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", s_ready, 0);
    check("rst_enb", enb, 0);
    check("rst_addr", addr, 12'h000);
    check("rst_re", re, 0);
    check("rst_we", we, 0);
    check("rst_wdata", wdata, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    res = 1'b0;
    repeat (2) @(negedge clk);

    tx.delete(); tx.push_back(8'hA5); tx.push_back(8'h5A); tx.push_back(8'hFF);
    run_load(3, 0, 0, 1'b0);
    check_load("stream", 3, 1'b0);
    if (wc.size() >= 3) check("stream_we_span", wc[2] - wc[0], 2);

    fill_tx(2);
    run_load(2, 3, 0, 1'b0);
    check_load("throttle", 2, 1'b0);
    if (wc.size() >= 2) check("throttle_gap", wc[1] - wc[0], 4);

    for (int k = 0; k < 4; k++) begin
      n = $urandom_range(1, 40);
      fill_tx(n);
      run_load(n, 0, 2, 1'b0);
      check_load("random", n, 1'b0);
    end

    fill_tx(6);
    run_load(6, 0, 0, 1'b1);
    check_load("start_busy", 6, 1'b0);

    fill_tx(4096);
    run_load(4096, 0, 0, 1'b0);
    check_load("full", 4096, 1'b0);
    if (wa.size() > 0) check("full_last_addr", wa[wa.size() - 1], 12'hFFF);

`ifdef ROM_INIT_LOADER_VERIFY_EN
    tx.delete(); tx.push_back(8'hA5); tx.push_back(8'h5A); tx.push_back(8'hFF);
    run_load(3, 0, 0, 1'b0);
    check_load("verify_ok", 3, 1'b0);
    corrupt = 1'b1;
    run_load(3, 0, 0, 1'b0);
    check_load("verify_bad", 3, 1'b1);
    check("verify_err_held", err, 1);
    corrupt = 1'b0;
    run_load(3, 0, 0, 1'b0);
    check_load("verify_clear", 3, 1'b0);
`endif

    fill_tx(4);
    @(negedge clk);
    clear_logs();
    start = 1'b1; len = 12'd4;
    @(negedge clk);
    start = 1'b0; sent = 0; guard = 0;
    while (sent < 2 && guard < 50) begin
      s_valid = 1'b1; s_data = tx[sent];
      xfer = s_ready;
      @(negedge clk);
      guard++;
      if (xfer) sent++;
    end
    res = 1'b1; s_valid = 1'b0;
    @(negedge clk);
    res = 1'b0;
    check("abort_enb", enb, 0);
    check("abort_we", we, 0);
    check("abort_busy", busy, 0);
    repeat (20) @(negedge clk);
    check("abort_done_count", dc.size(), 0);
    check("abort_we_count", wa.size(), 2);

    check("re_we_overlap", overlap, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
